// File: rtl/pxie_c2h_read_ctrl.sv
// pxie_c2h_read_ctrl
//   Card-to-host read engine. A one-cycle start strobe latches a word address
//   and a length; the block then streams that many RAM words out through a
//   small output FIFO with valid/ready handshaking. Reads are only issued
//   while the FIFO has room for every read already in flight, so RAM data
//   (which cannot be stalled) is never lost.
//
//   Optional feature: define PXIE_C2H_HEADER_EN to prepend one header word
//   {64'h0, 16'heb9c, 16'h1010, length[15:0], address[15:0]} to each stream.
//
// Parameters
//   ADDR_W      RAM word-address width
//   DATA_W      RAM / stream data width
//   RD_LAT      RAM read latency in cycles (1..4)
//   FIFO_DEPTH  output FIFO depth, power of 2, >= RD_LAT+2
//
// Ports
//   I_PXIE_CLK, I_Rst_n          clock, asynchronous active-low reset
//   I_c2h_en/_addr/_len          start strobe with address and length
//   O_ram_rden/_addr, I_ram_rdata RAM read port (data RD_LAT cycles later)
//   O_c2h_data/_vld, I_c2h_rdy   output stream
//   O_busy, O_done, O_start_drop status: busy, completion pulse, ignored start
module pxie_c2h_read_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 128,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              I_PXIE_CLK,
  input  logic              I_Rst_n,
  input  logic              I_c2h_en,
  input  logic [15:0]       I_c2h_addr,
  input  logic [15:0]       I_c2h_len,
  output logic              O_ram_rden,
  output logic [ADDR_W-1:0] O_ram_addr,
  input  logic [DATA_W-1:0] I_ram_rdata,
  output logic [DATA_W-1:0] O_c2h_data,
  output logic              O_c2h_vld,
  input  logic              I_c2h_rdy,
  output logic              O_busy,
  output logic              O_done,
  output logic              O_start_drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef PXIE_C2H_HEADER_EN
  localparam int HDR_EN = 1;
`else
  localparam int HDR_EN = 0;
`endif

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_HDR   = 5'b00010,
    S_READ  = 5'b00100,
    S_DRAIN = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       hdr_addr_reg;
  logic [16:0]       len_reg, total_reg, issued_reg, xfer_reg;
  logic [RD_LAT-1:0] dly_reg;
  logic [CNT_W-1:0]  inflight_reg, count_reg;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic start_ok, can_issue, rd_go, hdr_wr, data_wr, push, pop, xfer_all;
  logic [DATA_W-1:0] hdr_word;

  assign start_ok = I_c2h_en && (state_reg == S_IDLE);
  // Credit: reads in flight plus words already buffered must fit in the FIFO.
  assign can_issue = (issued_reg < len_reg) &&
                     (({1'b0, inflight_reg} + {1'b0, count_reg}) < (CNT_W+1)'(FIFO_DEPTH));
  assign rd_go    = (state_reg == S_READ) && can_issue;
  assign hdr_wr   = (state_reg == S_HDR);
  assign data_wr  = dly_reg[RD_LAT-1];
  assign push     = hdr_wr || data_wr;
  assign pop      = O_c2h_vld && I_c2h_rdy;
  // Last word leaves this cycle, or everything had already left (short or
  // header-only streams can finish before DRAIN is reached).
  assign xfer_all = (xfer_reg + {16'd0, pop}) == total_reg;
  assign hdr_word = DATA_W'({16'heb9c, 16'h1010, len_reg[15:0], hdr_addr_reg});

  // State register
  always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
`ifdef PXIE_C2H_HEADER_EN
        if (I_c2h_en) state_next = S_HDR;
`else
        // Zero-length transfer has nothing to read or drain: finish at once.
        if (I_c2h_en) state_next = (I_c2h_len == 16'd0) ? S_DRAIN : S_READ;
`endif
      end
      S_HDR:   state_next = S_READ;
      S_READ:  if (issued_reg == len_reg) state_next = S_DRAIN;
      S_DRAIN: if (xfer_all) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    O_ram_rden   = rd_go;
    O_ram_addr   = addr_reg;
    O_busy       = (state_reg != S_IDLE);
    O_done       = (state_reg == S_DONE);
    O_start_drop = I_c2h_en && (state_reg != S_IDLE);
    O_c2h_vld    = (count_reg != '0);
    O_c2h_data   = O_c2h_vld ? mem[rd_ptr_reg] : '0;
  end

  // Transfer bookkeeping
  always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      addr_reg     <= '0;
      hdr_addr_reg <= '0;
      len_reg      <= '0;
      total_reg    <= '0;
      issued_reg   <= '0;
      xfer_reg     <= '0;
    end else if (start_ok) begin
      addr_reg     <= ADDR_W'(I_c2h_addr);
      hdr_addr_reg <= I_c2h_addr;
      len_reg      <= {1'b0, I_c2h_len};
      total_reg    <= {1'b0, I_c2h_len} + 17'(HDR_EN);
      issued_reg   <= '0;
      xfer_reg     <= '0;
    end else begin
      if (rd_go) begin
        addr_reg   <= addr_reg + ADDR_W'(1);
        issued_reg <= issued_reg + 17'd1;
      end
      if (pop) xfer_reg <= xfer_reg + 17'd1;
    end
  end

  // Delay line of read enables: a set bit at the end marks valid RAM data.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_dly
      if (gi == 0) begin : g_head
        always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
          if (!I_Rst_n) dly_reg[gi] <= 1'b0;
          else          dly_reg[gi] <= rd_go;
        end
      end else begin : g_tail
        always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
          if (!I_Rst_n) dly_reg[gi] <= 1'b0;
          else          dly_reg[gi] <= dly_reg[gi-1];
        end
      end
    end
  endgenerate

  // FIFO pointers, occupancy and in-flight read count
  always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= '0;
    end else begin
      inflight_reg <= inflight_reg + CNT_W'(rd_go) - CNT_W'(data_wr);
      count_reg    <= count_reg + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  // FIFO storage (no reset; contents are only visible while occupied)
  always_ff @(posedge I_PXIE_CLK) begin
    if (push) mem[wr_ptr_reg] <= hdr_wr ? hdr_word : I_ram_rdata;
  end

endmodule

// File: tb/tb_pxie_c2h_read_ctrl.sv
// Self-checking bench for pxie_c2h_read_ctrl: a queue-based model of the
// expected read addresses and stream words, checked every cycle on the
// falling edge, plus literal timing/value pins for the directed cases.
module tb_pxie_c2h_read_ctrl;
  localparam int ADDR_W = 16, DATA_W = 128, RD_LAT = 2, FIFO_DEPTH = 8;
`ifdef PXIE_C2H_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, rdy = 1'b1;
  logic [15:0] addr = '0, len = '0;
  logic rden, vld, busy, done, drop;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata, data;

  always #5 clk = ~clk;

  pxie_c2h_read_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .I_PXIE_CLK(clk), .I_Rst_n(rst_n), .I_c2h_en(en), .I_c2h_addr(addr), .I_c2h_len(len),
    .O_ram_rden(rden), .O_ram_addr(raddr), .I_ram_rdata(rdata),
    .O_c2h_data(data), .O_c2h_vld(vld), .I_c2h_rdy(rdy),
    .O_busy(busy), .O_done(done), .O_start_drop(drop));

  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ram_word(input logic [15:0] a);
    return {a ^ 16'h5a5a, a + 16'd7, ~a, 16'hc0de, a, a * 16'd3, 16'h1234 ^ a, a - 16'd1};
  endfunction

  // RAM: data for the address presented with rden appears RD_LAT cycles later;
  // random garbage otherwise so mistimed captures are visible.
  logic [15:0] pa [RD_LAT];
  logic        pv [RD_LAT];
  logic [127:0] garb;
  always @(posedge clk) begin
    pa[0] <= raddr;
    pv[0] <= rden;
    for (int i = 1; i < RD_LAT; i++) begin
      pa[i] <= pa[i-1];
      pv[i] <= pv[i-1];
    end
    garb <= {$urandom, $urandom, $urandom, $urandom};
  end
  assign rdata = pv[RD_LAT-1] ? ram_word(pa[RD_LAT-1]) : garb;

  // Ready driver
  bit rdy_rand = 0, rdy_force = 1;
  initial forever begin
    @(posedge clk); #1;
    rdy = rdy_rand ? ($urandom_range(0, 9) < 7) : rdy_force;
  end

  // Reference model
  logic [127:0] exp_q[$];
  logic [15:0]  addr_q[$];
  logic [15:0]  alog[$];
  bit busy_exp = 0, prev_stall = 0;
  logic [127:0] prev_data, first_word;
  int cyc = 0, ndone = 0, ndrop = 0, issued_n = 0, popped_n = 0, hdr_n = 0;
  int st_cyc, f_rden, l_rden, f_vld, d_cyc, nrden;

  always @(negedge clk) begin
    bit bnext;
    logic [15:0] a;
    logic [127:0] e;
    if (!rst_n) begin
      exp_q.delete(); addr_q.delete();
      busy_exp = 0; prev_stall = 0; issued_n = 0; popped_n = 0; hdr_n = 0;
    end else begin
      bnext = busy_exp;
      chk("busy", busy, busy_exp);
      chk("start_drop", drop, en && busy_exp);
      if (drop) ndrop++;
      if (rden) begin
        chk("rden_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) begin
          a = addr_q.pop_front();
          chk("rden_addr", raddr, a);
          exp_q.push_back(ram_word(a));
          alog.push_back(raddr);
          issued_n++; nrden++;
          if (f_rden < 0) f_rden = cyc;
          l_rden = cyc;
        end
      end
      chk("credit", (hdr_n + issued_n - popped_n) <= FIFO_DEPTH, 1);
      if (prev_stall) begin
        chk("hold_vld", vld, 1);
        chk("hold_data", data, prev_data);
      end
      if (vld && busy_exp && f_vld < 0) begin
        f_vld = cyc;
        first_word = data;
      end
      if (vld && rdy) begin
        chk("vld_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("stream_data", data, e);
          popped_n++;
        end
      end
      if (done) begin
        chk("done_while_busy", busy_exp, 1);
        chk("done_after_all", exp_q.size() + addr_q.size(), 0);
        ndone++; d_cyc = cyc; bnext = 0;
      end
      prev_stall = vld && !rdy;
      prev_data = data;
      if (en && !busy_exp) begin
        bnext = 1; st_cyc = cyc; f_rden = -1; l_rden = -1; f_vld = -1; d_cyc = -1; nrden = 0;
        alog.delete(); exp_q.delete(); addr_q.delete();
        issued_n = 0; popped_n = 0; hdr_n = HDR;
        for (int i = 0; i < int'(len); i++) addr_q.push_back(16'(addr + 16'(i)));
        if (HDR != 0) exp_q.push_back({64'h0, 16'heb9c, 16'h1010, len, addr});
      end
      busy_exp = bnext;
    end
    cyc++;
  end

  // Start a transfer and wait for its completion; dup=1/2 re-strobes en
  // that many cycles after the accepted start.
  task automatic run_xfer(input logic [15:0] a, input logic [15:0] l, input int dup);
    int k, nd0;
    k = 0;
    while (busy_exp && k < 5000) begin @(posedge clk); k++; end
    nd0 = ndone;
    @(posedge clk); #1;
    en = 1; addr = a; len = l;
    for (int j = 1; j <= 2; j++) begin
      @(posedge clk); #1;
      en = (dup == j);
      addr = 16'($urandom); len = 16'($urandom);
    end
    @(posedge clk); #1; en = 0;
    k = 0;
    while (ndone == nd0 && k < 4000) begin @(posedge clk); k++; end
    chk("done_seen", ndone != nd0, 1);
    #1;
    $display("[TB] xfer addr=%h len=%0d start=%0d first_rden=%0d first_vld=%0d done=%0d words=%0d",
             a, l, st_cyc, f_rden, f_vld, d_cyc, popped_n);
  endtask

  initial begin
    logic [15:0] wrap_exp [4];
    int nd0, nr30, ndr0;
    wrap_exp[0] = 16'hfffe; wrap_exp[1] = 16'hffff; wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rden", rden, 0); chk("rst_addr", raddr, 0); chk("rst_vld", vld, 0);
    chk("rst_data", data, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_drop", drop, 0);
    rst_n = 1;
    repeat (2) @(posedge clk);

    // Basic 4-word transfer with ready high
    nd0 = ndone;
    run_xfer(16'h0010, 16'd4, 0);
    chk("basic_first_rden_lat", f_rden - st_cyc, 1 + HDR);
    chk("basic_rden_span", l_rden - f_rden, 3);
    chk("basic_nrden", nrden, 4);
    for (int i = 0; i < 4; i++) chk("basic_rden_addr", alog[i], 16'h0010 + 16'(i));
`ifdef PXIE_C2H_HEADER_EN
    chk("basic_first_vld_lat", f_vld - st_cyc, 2);
`else
    chk("basic_first_vld_lat", f_vld - st_cyc, RD_LAT + 2);
    chk("basic_first_word", first_word, ram_word(16'h0010));
`endif
    repeat (5) @(posedge clk);
    chk("basic_one_done", ndone - nd0, 1);

    // Address wrap
    run_xfer(16'hfffe, 16'd4, 0);
    for (int i = 0; i < 4; i++) chk("wrap_addr", alog[i], wrap_exp[i]);

    // Zero length
    run_xfer(16'h1234, 16'd0, 0);
    chk("len0_nrden", nrden, 0);
`ifdef PXIE_C2H_HEADER_EN
    chk("len0_header", first_word, {64'h0, 16'heb9c, 16'h1010, 16'h0000, 16'h1234});
    chk("len0_words", popped_n, 1);
`else
    chk("len0_done_lat", d_cyc - st_cyc, 2);
    chk("len0_no_vld", f_vld, -1);
`endif

    // Header layout / plain first word
    run_xfer(16'h0100, 16'd2, 0);
`ifdef PXIE_C2H_HEADER_EN
    chk("hdr_word", first_word, 128'h0000_0000_0000_0000_eb9c_1010_0002_0100);
`else
    chk("first_word_0100", first_word, ram_word(16'h0100));
`endif
    chk("hdr_xfer_words", popped_n, 2 + HDR);

    // Back-pressure: ready low for 30 cycles
    rdy_force = 0;
    fork
      run_xfer(16'h0400, 16'd20, 0);
      begin
        repeat (30) @(posedge clk);
        nr30 = nrden;
        rdy_force = 1;
      end
    join
    chk("stall_rden_bounded", nr30 <= FIFO_DEPTH, 1);
    chk("stall_rden_some", nr30 > 0, 1);
    chk("stall_all_words", popped_n, 20 + HDR);

    // Second start while busy
    ndr0 = ndrop;
    run_xfer(16'h0200, 16'd6, 1);
    chk("dup_drop_count", ndrop - ndr0, 1);
    chk("dup_words", popped_n, 6 + HDR);

    // Reset in the middle of a transfer
    @(posedge clk); #1; en = 1; addr = 16'h0300; len = 16'd30;
    @(posedge clk); #1; en = 0;
    repeat (5) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("mid_rst_rden", rden, 0); chk("mid_rst_addr", raddr, 0); chk("mid_rst_vld", vld, 0);
    chk("mid_rst_data", data, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    nd0 = ndone;
    repeat (40) @(posedge clk);
    chk("mid_rst_no_done", ndone, nd0);
    $display("[TB] xfer addr=0300 len=30 abandoned by reset");

    // Randomized transfers with random ready
    rdy_rand = 1;
    for (int t = 0; t < 25; t++) begin
      run_xfer(16'($urandom), 16'($urandom_range(0, 40)),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0);
    end
    rdy_rand = 0; rdy_force = 1;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    tests++; fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pxie_c2h_read_ctrl.md
PXIE_C2H_READ_CTRL -- requirements
Module: pxie_c2h_read_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, default 16: RAM word-address width.
- DATA_W, default 128: RAM and stream data width.
- RD_LAT, default 2: RAM read latency in cycles, legal range 1..4.
- FIFO_DEPTH, default 8: output buffer depth in words, power of 2, at least RD_LAT+2.

REQ-002 The block SHALL have one clock, I_PXIE_CLK, and an asynchronous, active-low reset, I_Rst_n. It SHALL have these ports:
- I_PXIE_CLK  in  1  clock; all logic on rising edge.
- I_Rst_n  in  1  asynchronous active-low reset.
- I_c2h_en  in  1  start strobe, one cycle.
- I_c2h_addr  in  16  start word address, sampled with I_c2h_en.
- I_c2h_len  in  16  transfer length in words, sampled with I_c2h_en.
- O_ram_rden  out  1  RAM read enable.
- O_ram_addr  out  ADDR_W  RAM read address.
- I_ram_rdata  in  DATA_W  RAM data, valid RD_LAT cycles after O_ram_rden.
- O_c2h_data  out  DATA_W  stream data.
- O_c2h_vld  out  1  stream valid.
- I_c2h_rdy  in  1  stream ready; a transfer occurs when O_c2h_vld and I_c2h_rdy are both high.
- O_busy  out  1  high from the cycle after an accepted start until the cycle of O_done.
- O_done  out  1  one-cycle completion pulse.
- O_start_drop  out  1  one-cycle pulse when a start is ignored.

Function
REQ-003 The state machine SHALL have the states IDLE, HDR, READ, DRAIN and DONE, using one-hot encoding.

REQ-004 In IDLE, I_c2h_en SHALL latch the address and length and move to HDR (macro defined) or READ (macro undefined).

REQ-005 READ SHALL assert O_ram_rden, with O_ram_addr equal to the current address, whenever the issued-word count is below the length and the sum of outstanding reads plus FIFO occupancy is below FIFO_DEPTH.

REQ-006 The first O_ram_rden SHALL occur in the cycle after I_c2h_en, or in the cycle after the header is written into the FIFO when the macro is defined.

REQ-007 The read address SHALL increment by 1 per issued read and SHALL wrap modulo 2^ADDR_W. I_c2h_addr SHALL be zero-extended or truncated to ADDR_W.

REQ-008 I_ram_rdata SHALL be written into the FIFO exactly RD_LAT cycles after each O_ram_rden, using a delay line of rden bits.

REQ-009 O_c2h_vld SHALL assert one cycle after a word is written into an empty FIFO; the first data word appears RD_LAT+2 cycles after I_c2h_en (macro undefined).

REQ-010 While O_c2h_vld is high and I_c2h_rdy is low, O_c2h_data and O_c2h_vld SHALL hold stable.

REQ-011 With the FIFO full, no read SHALL be issued; the credit rule in REQ-005 guarantees that RAM data is never dropped.

REQ-012 When the issued-word count equals the length, the block SHALL go to DRAIN. DRAIN SHALL go to DONE on the cycle in which the last word is transferred on the stream.

REQ-013 DONE SHALL last one cycle, assert O_done, and return to IDLE.

REQ-014 A length of 0 SHALL issue no reads. The block SHALL go to DRAIN, and reach DONE once the FIFO is empty (immediately when the macro is undefined).

REQ-015 I_c2h_en outside IDLE SHALL be ignored and SHALL pulse O_start_drop for one cycle. I_c2h_en in the DONE cycle is likewise dropped.

REQ-016 Counters SHALL be 17 bits so that a length of 65535 completes without overflow.

REQ-017 O_busy SHALL be high in the HDR, READ and DRAIN states, and in the DONE state.

Reset
REQ-018 Asserting I_Rst_n low SHALL immediately:
- force the state to IDLE;
- clear all counters, the FIFO pointers and the rden delay line;
- drive O_ram_rden, O_c2h_vld, O_busy, O_done and O_start_drop to 0;
- drive O_ram_addr and O_c2h_data to 0.

REQ-019 A reset in the middle of a transfer SHALL abandon it. Reads still in flight SHALL be discarded and no O_done SHALL be produced.

Configuration
REQ-020 The macro PXIE_C2H_HEADER_EN SHALL control whether a header word is sent.
- When defined, HDR SHALL write one header word into the FIFO, then move to READ.
- Header layout: [127:64]=0, [63:48]=16'heb9c, [47:32]=16'h1010, [31:16]=length, [15:0]=address.
- The header is the first stream word; the total stream length is the transfer length plus 1.
- When undefined, HDR is unreachable and no header is sent.

Verification
REQ-021 Start with addr=0x0010 and len=4, I_c2h_rdy held high, macro undefined -> rden at addresses 0x10..0x13 on 4 consecutive cycles; 4 stream words equal to RAM[0x10..0x13], the first 4 cycles after start; O_done pulses once.

REQ-022 len=20 with I_c2h_rdy low for the first 30 cycles -> at most FIFO_DEPTH reads are issued, data is held stable, all 20 words arrive in order after rdy rises, and none are lost.

REQ-023 addr=0xFFFE and len=4 -> read addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.

REQ-024 len=0 -> no rden; O_done pulses 2 cycles after start (macro undefined). With the macro defined, a single header word with [31:16]=0 is sent, then O_done.

REQ-025 Second start during a transfer -> O_start_drop pulses and the first transfer is unaffected. Reset asserted mid-transfer -> all outputs go to 0 at once and no O_done follows.

REQ-026 Macro defined, addr=0x0100, len=2 -> first stream word is 0x...eb9c_1010_0002_0100, followed by RAM[0x100] and RAM[0x101].
